vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Upstream stage of the block/paddle renderer: VGA 640x480@60 timing generator.
//  - Divides the 100 MHz board clock to a 25 MHz pixel enable.
//  - Produces hCount/vCount, hSync/vSync and bright; the renderer consumes them to choose rgb.
//  - Produces frame_tick, a one-clk pulse at the start of vertical blanking. Game logic uses it
//    to update paddle and block state without tearing.
// PARAMETERS
//  PIX_DIV       4    clk cycles per pixel (100 MHz -> 25 MHz); must be >= 2
//  H_TOTAL       800  pixels per line, hCount range 0..H_TOTAL-1
//  H_SYNC        96   hSync low while hCount < H_SYNC
//  H_DISP_START  144  first visible column
//  H_DISP_END    784  first column after the visible area (exclusive)
//  V_TOTAL       525  lines per frame, vCount range 0..V_TOTAL-1
//  V_SYNC        2    vSync low while vCount < V_SYNC
//  V_DISP_START  35   first visible line
//  V_DISP_END    515  first line after the visible area (exclusive)
// PORTS
//  clk         in   1   100 MHz system clock; all logic is on posedge
//  rst         in   1   synchronous, active-high reset
//  pix_en      out  1   one-clk pulse every PIX_DIV clks; counters advance only on it
//  hCount      out  10  current column, 0..H_TOTAL-1
//  vCount      out  10  current line, 0..V_TOTAL-1
//  hSync       out  1   active-low horizontal sync
//  vSync       out  1   active-low vertical sync
//  bright      out  1   high inside the visible 640x480 window
//  frame_tick  out  1   one-clk pulse when the counters enter (0, V_DISP_END)
// BEHAVIOUR
//  - Reset values: div=0, pix_en=0, hCount=0, vCount=0, hSync=0, vSync=0, bright=0,
//    frame_tick=0. Reset mid-frame forces these values on the next edge. The first pix_en
//    after reset release comes PIX_DIV clks later.
//  - Divider: counts 0..PIX_DIV-1 and wraps. pix_en is registered and is high for the
//    single clk after the divider reaches PIX_DIV-1.
//  - On a pix_en cycle:
//      hCount==H_TOTAL-1 -> hCount=0, and vCount advances.
//      Otherwise hCount+1, vCount unchanged.
//      vCount advances as: vCount==V_TOTAL-1 -> vCount=0, else vCount+1.
//    Both counters hold between pix_en pulses.
//  - hSync, vSync, bright and frame_tick are registered and computed from the next counter
//    values, so they change on the same edge as hCount/vCount.
//    Zero-latency relation: hSync = (hCount >= H_SYNC) and vSync = (vCount >= V_SYNC).
//    bright = H_DISP_START <= hCount < H_DISP_END and V_DISP_START <= vCount < V_DISP_END.
//  - frame_tick is high for exactly one clk, on the edge where the counters become
//    (0, V_DISP_END). That is once per H_TOTAL*V_TOTAL*PIX_DIV = 1,680,000 clks.
//  - Compares are unsigned and 10 bits wide. No counter ever exceeds its TOTAL-1; there is
//    no overflow path.
// STRUCTURE
//  - vga_timing_pkg: the nine timing constants plus the 10-bit count width localparam.
//    The renderer imports the same constants for its display-area offsets.
//  - Sub-module clk_en_div (PIX_DIV): divider counter plus registered pix_en.
//  - Top level: h/v counters and the registered decode. No FSM beyond the counters.
// TESTING
//  1. Hold rst 3 clks, then release -> all outputs 0; first pix_en exactly 4 clks after release.
//  2. Free run 40 clks -> pix_en period 4 clks; hCount 0..9 with vCount=0.
//  3. Run to hCount=799, vCount=0; next pix_en -> hCount=0, vCount=1.
//     At vCount=524, hCount=799 -> wraps to (0,0).
//  4. Sweep one line -> hSync 0 for hCount 0..95 and 1 at 96.
//     Sweep lines -> vSync 0 for vCount 0..1 and 1 at 2.
//  5. bright corner checks:
//       1 at (144,35) and (783,514)
//       0 at (143,35), (784,35), (144,34) and (144,515).
//  6. Run 2 frames -> exactly 2 frame_tick pulses, 1,680,000 clks apart, each at (0,515).
//     Assert rst at (400,200) -> (0,0) and all outputs 0 on the next edge.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants. The renderer imports the same
// constants for its display-area offsets.
package vga_timing_pkg;

  // Width of hCount/vCount and of every timing compare.
  localparam int CNT_W = 10;

  localparam int VGA_PIX_DIV      = 4;    // 100 MHz clk -> 25 MHz pixel enable
  localparam int VGA_H_TOTAL      = 800;
  localparam int VGA_H_SYNC       = 96;
  localparam int VGA_H_DISP_START = 144;
  localparam int VGA_H_DISP_END   = 784;
  localparam int VGA_V_TOTAL      = 525;
  localparam int VGA_V_SYNC       = 2;
  localparam int VGA_V_DISP_START = 35;
  localparam int VGA_V_DISP_END   = 515;

endpackage

// File: rtl/clk_en_div.sv
// Clock-enable divider: counts 0..PIX_DIV-1 and raises a registered one-clk
// enable on the clk after the count reaches its last value.
module clk_en_div #(
  parameter int PIX_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_pix_en
);

  localparam int DIV_W = $clog2(PIX_DIV);
  localparam logic [DIV_W-1:0] L_DIV_LAST = DIV_W'(PIX_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic             r_pix_en;
  logic             w_div_last;

  assign w_div_last = (r_div == L_DIV_LAST);

  // Free-running divider; pix_en follows the terminal count by one clk.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div    <= '0;
      r_pix_en <= 1'b0;
    end else begin
      r_pix_en <= w_div_last;
      r_div    <= w_div_last ? '0 : r_div + DIV_W'(1);
    end
  end

  assign o_pix_en = r_pix_en;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel enable, h/v counters and registered sync,
// bright and frame_tick decode. The decode is computed from the next counter
// values so every output changes on the same edge as hCount/vCount.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int PIX_DIV      = VGA_PIX_DIV,
  parameter int H_TOTAL      = VGA_H_TOTAL,
  parameter int H_SYNC       = VGA_H_SYNC,
  parameter int H_DISP_START = VGA_H_DISP_START,
  parameter int H_DISP_END   = VGA_H_DISP_END,
  parameter int V_TOTAL      = VGA_V_TOTAL,
  parameter int V_SYNC       = VGA_V_SYNC,
  parameter int V_DISP_START = VGA_V_DISP_START,
  parameter int V_DISP_END   = VGA_V_DISP_END
) (
  input  logic             clk,
  input  logic             rst,
  output logic             pix_en,
  output logic [CNT_W-1:0] hCount,
  output logic [CNT_W-1:0] vCount,
  output logic             hSync,
  output logic             vSync,
  output logic             bright,
  output logic             frame_tick
);

  localparam logic [CNT_W-1:0] L_H_LAST       = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] L_H_SYNC       = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] L_H_DISP_START = CNT_W'(H_DISP_START);
  localparam logic [CNT_W-1:0] L_H_DISP_END   = CNT_W'(H_DISP_END);
  localparam logic [CNT_W-1:0] L_V_LAST       = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] L_V_SYNC       = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] L_V_DISP_START = CNT_W'(V_DISP_START);
  localparam logic [CNT_W-1:0] L_V_DISP_END   = CNT_W'(V_DISP_END);

  logic             w_pix_en;
  logic [CNT_W-1:0] w_h_next;
  logic [CNT_W-1:0] w_v_next;
  logic             w_h_wrap;

  logic [CNT_W-1:0] r_h_count;
  logic [CNT_W-1:0] r_v_count;
  logic             r_h_sync;
  logic             r_v_sync;
  logic             r_bright;
  logic             r_frame_tick;

  clk_en_div #(
    .PIX_DIV (PIX_DIV)
  ) u_clk_en_div (
    .i_clk    (clk),
    .i_rst    (rst),
    .o_pix_en (w_pix_en)
  );

  // Next raster position: column wraps at end of line, line wraps at end of frame.
  always_comb begin
    w_h_wrap = (r_h_count == L_H_LAST);
    w_h_next = r_h_count + CNT_W'(1);
    w_v_next = r_v_count;
    if (w_h_wrap) begin
      w_h_next = '0;
      w_v_next = (r_v_count == L_V_LAST) ? '0 : r_v_count + CNT_W'(1);
    end
  end

  // Counters and decode advance together on pix_en; frame_tick lasts one clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_count    <= '0;
      r_v_count    <= '0;
      r_h_sync     <= 1'b0;
      r_v_sync     <= 1'b0;
      r_bright     <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= 1'b0;
      if (w_pix_en) begin
        r_h_count    <= w_h_next;
        r_v_count    <= w_v_next;
        r_h_sync     <= (w_h_next >= L_H_SYNC);
        r_v_sync     <= (w_v_next >= L_V_SYNC);
        r_bright     <= (w_h_next >= L_H_DISP_START) && (w_h_next < L_H_DISP_END) &&
                        (w_v_next >= L_V_DISP_START) && (w_v_next < L_V_DISP_END);
        r_frame_tick <= (w_h_next == '0) && (w_v_next == L_V_DISP_END);
      end
    end
  end

  assign pix_en     = w_pix_en;
  assign hCount     = r_h_count;
  assign vCount     = r_v_count;
  assign hSync      = r_h_sync;
  assign vSync      = r_v_sync;
  assign bright     = r_bright;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. One instance uses the real 640x480 geometry, a
// second uses a shrunken raster so whole frames fit in a short run.
module tb_vga_timing_gen;

  // Shrunken geometry for the frame-level instance.
  localparam int S_PD  = 4;
  localparam int S_HT  = 40;
  localparam int S_HS  = 6;
  localparam int S_HDS = 9;
  localparam int S_HDE = 37;
  localparam int S_VT  = 20;
  localparam int S_VS  = 2;
  localparam int S_VDS = 4;
  localparam int S_VDE = 17;
  localparam int S_FRAME = S_HT * S_VT * S_PD;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       f_pe, f_hs, f_vs, f_br, f_ft;
  logic [9:0] f_h, f_v;
  logic       s_pe, s_hs, s_vs, s_br, s_ft;
  logic [9:0] s_h, s_v;

  vga_timing_gen dut_full (
    .clk(clk), .rst(rst), .pix_en(f_pe), .hCount(f_h), .vCount(f_v),
    .hSync(f_hs), .vSync(f_vs), .bright(f_br), .frame_tick(f_ft)
  );

  vga_timing_gen #(
    .PIX_DIV(S_PD), .H_TOTAL(S_HT), .H_SYNC(S_HS), .H_DISP_START(S_HDS),
    .H_DISP_END(S_HDE), .V_TOTAL(S_VT), .V_SYNC(S_VS), .V_DISP_START(S_VDS),
    .V_DISP_END(S_VDE)
  ) dut_small (
    .clk(clk), .rst(rst), .pix_en(s_pe), .hCount(s_h), .vCount(s_v),
    .hSync(s_hs), .vSync(s_vs), .bright(s_br), .frame_tick(s_ft)
  );

  logic [24:0] f_vec, s_vec;
  assign f_vec = {f_pe, f_h, f_v, f_hs, f_vs, f_br, f_ft};
  assign s_vec = {s_pe, s_h, s_v, s_hs, s_vs, s_br, s_ft};

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;
  logic [31:0] exp_q[$];

  // ---------------- reference model ----------------
  // Closed form: after n clk edges since reset, the divider has produced
  // pix_en after every PD-th edge and each pix_en clk moves the raster one pixel.
  longint n_clk;
  always @(posedge clk) begin
    if (rst) n_clk <= 0;
    else     n_clk <= n_clk + 1;
  end

  function automatic logic [24:0] model(longint n, int pd, int ht, int hsl, int hds, int hde,
                                        int vt, int vsl, int vds, int vde);
    longint p;
    int h, v;
    logic pe, moved, hs, vs, br, ft;
    p     = (n == 0) ? 0 : (n - 1) / pd;
    h     = int'(p % ht);
    v     = int'((p / ht) % vt);
    pe    = (n >= pd) && (n % pd == 0);
    moved = (n > pd) && ((n - 1) % pd == 0);
    hs    = (h >= hsl);
    vs    = (v >= vsl);
    br    = (h >= hds) && (h < hde) && (v >= vds) && (v < vde);
    ft    = moved && (h == 0) && (v == vde);
    return {pe, 10'(h), 10'(v), hs, vs, br, ft};
  endfunction

  // Every clk, both instances must match the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [24:0] ef, es;
      ef = model(n_clk, 4, 800, 96, 144, 784, 525, 2, 35, 515);
      es = model(n_clk, S_PD, S_HT, S_HS, S_HDS, S_HDE, S_VT, S_VS, S_VDS, S_VDE);
      checks = checks + 2;
      if (f_vec !== ef) begin
        failures = failures + 1;
        $display("FAIL model_full n=%0d got=%h exp=%h", n_clk, f_vec, ef);
      end
      if (s_vec !== es) begin
        failures = failures + 1;
        $display("FAIL model_small n=%0d got=%h exp=%h", n_clk, s_vec, es);
      end
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic check(input string name, input longint got, input longint exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_point(input bit sel, input int h, input int v, input int budget,
                            output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (sel ? (f_h == 10'(h) && f_v == 10'(v)) : (s_h == 10'(h) && s_v == 10'(v))) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks   = checks + 1;
      failures = failures + 1;
      $display("FAIL wait_point sel=%0d target=(%0d,%0d) not reached in %0d clks", sel, h, v, budget);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit   sel;   // 1 = full geometry, 0 = small geometry
    int   h;
    int   v;
    logic hs;
    logic vs;
    logic br;
  } vec_t;

  vec_t tbl[16];

  initial begin
    bit ok;
    int first_k;
    int tick_cnt;
    int last_tick;

    rst = 1'b1;

    // Small raster, in scan order: sync edges and bright window corners.
    tbl[0]  = '{0,  5,  0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{0,  6,  0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{0,  0,  1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{0,  0,  2, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{0,  9,  3, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{0,  8,  4, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{0,  9,  4, 1'b1, 1'b1, 1'b1};
    tbl[7]  = '{0, 37,  4, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{0, 36, 16, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{0,  9, 17, 1'b1, 1'b1, 1'b0};
    // Full raster: hSync edge at 96, vSync edge at line 2.
    tbl[10] = '{1, 95,  0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1, 96,  0, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1, 799, 0, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1,  0,  1, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1, 144, 1, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1,  0,  2, 1'b0, 1'b1, 1'b0};

    // Reset state and first pix_en timing.
    do_reset(3);
    chk_en = 1'b1;
    check("reset_full_outputs", f_vec, 0);
    check("reset_small_outputs", s_vec, 0);
    first_k = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (s_pe && first_k < 0) first_k = k;
    end
    check("first_pix_en_clks", first_k, 4);
    check("free_run_full_h", f_h, 9);
    check("free_run_full_v", f_v, 0);
    check("free_run_small_h", s_h, 9);

    // Table of raster points.
    do_reset(1);
    for (int i = 0; i < 16; i++) begin
      if (i == 10) do_reset(1);
      wait_point(tbl[i].sel, tbl[i].h, tbl[i].v, 8000, ok);
      if (ok) begin
        if (tbl[i].sel)
          check($sformatf("tbl%0d_hs_vs_br", i), {f_hs, f_vs, f_br}, {tbl[i].hs, tbl[i].vs, tbl[i].br});
        else
          check($sformatf("tbl%0d_hs_vs_br", i), {s_hs, s_vs, s_br}, {tbl[i].hs, tbl[i].vs, tbl[i].br});
      end
    end

    // Full raster end-of-line wrap into line 1.
    do_reset(1);
    wait_point(1'b1, 799, 0, 4000, ok);
    if (ok) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (f_h != 10'd799) break;
      end
      check("full_wrap_h", f_h, 0);
      check("full_wrap_v", f_v, 1);
    end

    // Small raster end-of-frame wrap to (0,0).
    wait_point(1'b0, S_HT - 1, S_VT - 1, 4000, ok);
    if (ok) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (s_h != 10'(S_HT - 1)) break;
      end
      check("small_frame_wrap_h", s_h, 0);
      check("small_frame_wrap_v", s_v, 0);
    end

    // Two frames of the small raster: frame_tick timing and position.
    do_reset(2);
    exp_q.push_back(32'(S_VDE * S_HT * S_PD + 1));
    exp_q.push_back(32'(S_VDE * S_HT * S_PD + 1 + S_FRAME));
    tick_cnt  = 0;
    last_tick = -1;
    for (int k = 1; k <= 2 * S_FRAME + 200; k++) begin
      @(negedge clk);
      if (s_ft) begin
        tick_cnt = tick_cnt + 1;
        if (exp_q.size() > 0) check("tick_time", k, exp_q.pop_front());
        check("tick_h", s_h, 0);
        check("tick_v", s_v, S_VDE);
        if (last_tick >= 0) check("tick_spacing", k - last_tick, S_FRAME);
        last_tick = k;
      end
    end
    check("tick_count", tick_cnt, 2);

    // Reset in mid-frame clears everything on the next edge.
    wait_point(1'b0, S_HT / 2, S_VT / 2, 4000, ok);
    rst = 1'b1;
    @(negedge clk);
    check("midframe_reset_small", s_vec, 0);
    check("midframe_reset_full", f_vec, 0);
    rst = 1'b0;

    // Random run lengths between random-width reset pulses.
    for (int it = 0; it < 8; it++) begin
      repeat ($urandom_range(50, 900)) @(negedge clk);
      rst = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst = 1'b0;
    end
    repeat (200) @(negedge clk);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
